// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipeline stages, including the writeback select
// encoding and the MEM/WB register layout.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_NPC = 2'd2
    } wbsel_t;

    // Contents of the MEM/WB pipeline register; all-zero is a bubble.
    typedef struct packed {
        logic     valid;
        logic     reg_write;
        logic     halt;
        wbsel_t   sel;
        regbits_t reg_sel;
        word_t    npc;
        word_t    alu_out;
        word_t    dmemload;
    } mem_wb_t;

    // The link path (jal) takes priority over load data.
    function automatic wbsel_t wb_select(input logic jal, input logic memto_reg);
        if (jal)
            return WB_NPC;
        else if (memto_reg)
            return WB_MEM;
        else
            return WB_ALU;
    endfunction

    function automatic word_t wb_mux(input wbsel_t sel, input word_t alu_out,
                                     input word_t dmemload, input word_t npc);
        case (sel)
            WB_NPC:  return npc;
            WB_MEM:  return dmemload;
            default: return alu_out;
        endcase
    endfunction

endpackage

// File: rtl/stage_wb_if.sv
// Port bundle between the MEM/WB stage and the rest of the datapath.
interface stage_wb_if;
    import cpu_types_pkg::*;

    logic     en;
    logic     flush;
    logic     valid_in;
    logic     regWrite_in;
    logic     memtoReg_in;
    logic     jal_in;
    regbits_t regSel_in;
    logic     halt_in;
    word_t    npc_in;
    word_t    aluOut_in;
    word_t    dmemload_in;

    logic     wen;
    regbits_t wsel;
    word_t    wdat;
    logic     halt;
    logic     fwd_valid;

    modport wb (
        input  en, flush, valid_in, regWrite_in, memtoReg_in, jal_in,
               regSel_in, halt_in, npc_in, aluOut_in, dmemload_in,
        output wen, wsel, wdat, halt, fwd_valid
    );

    modport dp (
        output en, flush, valid_in, regWrite_in, memtoReg_in, jal_in,
               regSel_in, halt_in, npc_in, aluOut_in, dmemload_in,
        input  wen, wsel, wdat, halt, fwd_valid
    );

endinterface

// File: rtl/retire_counter.sv
// Wrapping retired-instruction counter; stops counting while frozen.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            count <= '0;
        else if (inc && !freeze)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/stage_wb.sv
// MEM/WB pipeline register and writeback stage with sticky halt.
// Build option: define WB_RETIRE_CNT_EN to add the retired-instruction counter.
module stage_wb
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_in,
    input  logic             regWrite_in,
    input  logic             memtoReg_in,
    input  logic             jal_in,
    input  logic [4:0]       regSel_in,
    input  logic             halt_in,
    input  logic [31:0]      npc_in,
    input  logic [31:0]      aluOut_in,
    input  logic [31:0]      dmemload_in,
    output logic             wen,
    output logic [4:0]       wsel,
    output logic [31:0]      wdat,
    output logic             halt,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] retired
);

    stage_wb_if bus ();

    assign bus.en          = en;
    assign bus.flush       = flush;
    assign bus.valid_in    = valid_in;
    assign bus.regWrite_in = regWrite_in;
    assign bus.memtoReg_in = memtoReg_in;
    assign bus.jal_in      = jal_in;
    assign bus.regSel_in   = regSel_in;
    assign bus.halt_in     = halt_in;
    assign bus.npc_in      = npc_in;
    assign bus.aluOut_in   = aluOut_in;
    assign bus.dmemload_in = dmemload_in;

    mem_wb_t q;
    mem_wb_t d;

    // NOTE: d gets a full default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        d = q;
        if (q.halt) begin
            d = q;
        end else if (bus.flush) begin
            d = '0;
        end else if (bus.en) begin
            d.valid     = bus.valid_in;
            d.reg_write = bus.regWrite_in;
            d.halt      = bus.valid_in & bus.halt_in;
            d.sel       = wb_select(bus.jal_in, bus.memtoReg_in);
            d.reg_sel   = bus.regSel_in;
            d.npc       = bus.npc_in;
            d.alu_out   = bus.aluOut_in;
            d.dmemload  = bus.dmemload_in;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            q <= '0;
        else
            q <= d;
    end

    // A latched halt never writes, even if it carried regWrite.
    assign bus.wen       = q.valid & q.reg_write & ~q.halt & (q.reg_sel != '0);
    assign bus.wsel      = q.reg_sel;
    assign bus.wdat      = wb_mux(q.sel, q.alu_out, q.dmemload, q.npc);
    assign bus.halt      = q.halt;
    assign bus.fwd_valid = bus.wen;

    assign wen       = bus.wen;
    assign wsel      = bus.wsel;
    assign wdat      = bus.wdat;
    assign halt      = bus.halt;
    assign fwd_valid = bus.fwd_valid;

`ifdef WB_RETIRE_CNT_EN
    logic retire_inc;

    assign retire_inc = en & ~flush & ~q.halt & valid_in;

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .CLK    (CLK),
        .RST    (RST),
        .inc    (retire_inc),
        .freeze (q.halt),
        .count  (retired)
    );
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb: directed test-plan cases plus random traffic
// compared every cycle against a behavioural model of the writeback stage.
module tb_stage_wb;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        en = 1'b0, flush = 1'b0, valid_in = 1'b0, regWrite_in = 1'b0;
    logic        memtoReg_in = 1'b0, jal_in = 1'b0, halt_in = 1'b0;
    logic [4:0]  regSel_in = '0;
    logic [31:0] npc_in = '0, aluOut_in = '0, dmemload_in = '0;
    logic        wen, halt, fwd_valid;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    // Model: the last instruction accepted into WB, its already-selected result,
    // the sticky halt and the number of instructions accepted since reset.
    bit          m_valid = 0, m_rw = 0, m_halt = 0;
    logic [4:0]  m_sel = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_cnt = '0;

    stage_wb #(.CNT_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .en          (en),
        .flush       (flush),
        .valid_in    (valid_in),
        .regWrite_in (regWrite_in),
        .memtoReg_in (memtoReg_in),
        .jal_in      (jal_in),
        .regSel_in   (regSel_in),
        .halt_in     (halt_in),
        .npc_in      (npc_in),
        .aluOut_in   (aluOut_in),
        .dmemload_in (dmemload_in),
        .wen         (wen),
        .wsel        (wsel),
        .wdat        (wdat),
        .halt        (halt),
        .fwd_valid   (fwd_valid),
        .retired     (retired)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_wen();
        return m_valid && m_rw && !m_halt && (m_sel != 5'd0);
    endfunction

    function automatic logic [31:0] exp_retired();
`ifdef WB_RETIRE_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_halt = 0; m_sel = '0; m_data = '0; m_cnt = '0;
    endtask

    // Applies one clock edge's worth of behaviour using the inputs held across it.
    task automatic model_advance();
        if (m_halt) return;
        if (flush) begin
            m_valid = 0; m_rw = 0; m_sel = '0; m_data = '0;
        end else if (en) begin
            if (valid_in) m_cnt = m_cnt + 1;
            m_valid = valid_in;
            m_rw    = regWrite_in;
            m_sel   = regSel_in;
            m_halt  = valid_in && halt_in;
            m_data  = jal_in ? npc_in : (memtoReg_in ? dmemload_in : aluOut_in);
        end
    endtask

    always @(negedge CLK) begin
        check("cmp_wen",       wen,       exp_wen());
        check("cmp_fwd_valid", fwd_valid, exp_wen());
        check("cmp_wsel",      wsel,      m_sel);
        check("cmp_wdat",      wdat,      m_data);
        check("cmp_halt",      halt,      m_halt);
        check("cmp_retired",   retired,   exp_retired());
    end

    task automatic drive(input bit e, input bit f, input bit v, input bit rw,
                         input bit mt, input bit j, input logic [4:0] s, input bit h,
                         input logic [31:0] n, input logic [31:0] a, input logic [31:0] d);
        en = e; flush = f; valid_in = v; regWrite_in = rw; memtoReg_in = mt;
        jal_in = j; regSel_in = s; halt_in = h; npc_in = n; aluOut_in = a; dmemload_in = d;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        model_advance();
    endtask

    task automatic rand_cycle(input bit allow_halt);
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              5'($urandom_range(0, 31)), allow_halt && ($urandom_range(0, 40) == 0),
              $urandom, $urandom, $urandom);
        step();
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check("rst_wen", wen, 1'b0);
        check("rst_wdat", wdat, 32'd0);
        check("rst_wsel", wsel, 5'd0);
        check("rst_halt", halt, 1'b0);
        check("rst_retired", retired, 32'd0);
        @(negedge CLK);
        #2;
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        check("init_wen", wen, 1'b0);
        check("init_retired", retired, 32'd0);
        #2;
        RST = 1'b0;

        // ALU write
        drive(1, 0, 1, 1, 0, 0, 5'd5, 0, 32'h0, 32'h0000_00FF, 32'h0);
        step();
        check("alu_wen", wen, 1'b1);
        check("alu_wsel", wsel, 5'd5);
        check("alu_wdat", wdat, 32'h0000_00FF);
        check("alu_fwd", fwd_valid, 1'b1);

        // Select priority
        drive(1, 0, 1, 1, 1, 0, 5'd6, 0, 32'h0, 32'h1111_1111, 32'hDEAD_BEEF);
        step();
        check("mem_wdat", wdat, 32'hDEAD_BEEF);
        drive(1, 0, 1, 1, 1, 1, 5'd31, 0, 32'h44, 32'h1111_1111, 32'hDEAD_BEEF);
        step();
        check("jal_wdat", wdat, 32'h44);
        check("jal_wsel", wsel, 5'd31);

        // Zero register, then hold
        drive(1, 0, 1, 1, 0, 0, 5'd0, 0, 32'h0, 32'h1234, 32'h0);
        step();
        check("zero_wen", wen, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 1, 0, 5'(i + 3), 0, $urandom, $urandom, $urandom);
            step();
            check("hold_wdat", wdat, 32'h1234);
            check("hold_wsel", wsel, 5'd0);
        end

        // Flush beats en
        drive(1, 1, 1, 1, 0, 0, 5'd9, 0, 32'h0, 32'h55, 32'h0);
        step();
        check("flush_wen", wen, 1'b0);
`ifdef WB_RETIRE_CNT_EN
        check("flush_retired", retired, 32'd4);
`else
        check("flush_retired", retired, 32'd0);
`endif

        for (int i = 0; i < 400; i++) rand_cycle(1'b0);

        // Asynchronous reset with a write latched
        drive(1, 0, 1, 1, 0, 0, 5'd12, 0, 32'h0, 32'hCAFE, 32'h0);
        step();
        check("pre_rst_wen", wen, 1'b1);
        do_reset();

        // Six instructions then a halt, then ten advances that must be ignored
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 1, 0, 0, 5'(i + 1), 0, 32'h0, $urandom, 32'h0);
            step();
        end
        drive(1, 0, 1, 1, 0, 0, 5'd7, 1, 32'h0, 32'h77, 32'h0);
        step();
        check("halt_set", halt, 1'b1);
        check("halt_wen", wen, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1, i == 4, 1, 1, 0, 0, 5'd3, 0, 32'h0, $urandom, 32'h0);
            step();
            check("halt_sticky", halt, 1'b1);
            check("halt_no_wen", wen, 1'b0);
        end
`ifdef WB_RETIRE_CNT_EN
        check("halt_retired", retired, 32'd7);
`else
        check("halt_retired", retired, 32'd0);
`endif

        // Random traffic including halts, from a clean reset
        do_reset();
        for (int i = 0; i < 400; i++) rand_cycle(1'b1);

        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- MEM/WB pipeline register plus writeback stage of the pipelined datapath; sits directly downstream of the memory stage.
- Latches MEM-stage results on pipeline advance, selects writeback data, and drives the register-file write port and the WB forwarding path.
- Holds the sticky processor halt.
- Counts retired instructions (optional feature below).

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; asynchronous, active-high.
- en  input  1  pipeline advance from the hazard unit (ihit/dhit based).
- flush  input  1  insert a bubble into WB on the next advance.
- valid_in  input  1  MEM slot holds a real instruction.
- regWrite_in  input  1  instruction writes the register file.
- memtoReg_in  input  1  select load data for writeback.
- jal_in  input  1  select npc (link) for writeback.
- regSel_in  input  5  destination register.
- halt_in  input  1  halt instruction reached MEM.
- npc_in  input  32  PC+4 of the instruction.
- aluOut_in  input  32  ALU result.
- dmemload_in  input  32  load data returned to MEM.
- wen  output  1  register-file write enable.
- wsel  output  5  register-file write select.
- wdat  output  32  register-file write data.
- halt  output  1  sticky halt to the datapath/system.
- fwd_valid  output  1  WB result available for forwarding (equals wen).
- retired  output  CNT_W  retired-instruction count (0 when the feature is absent).

Behaviour:
- Reset (async, RST=1): all latched fields 0.
  - wen=0, wsel=0, wdat=0, halt=0, fwd_valid=0, retired=0.
  - Clears immediately, mid-operation included.
- Latency: one cycle. Fields captured on the rising CLK edge with en=1 are visible on outputs the same cycle after that edge.
- Capture rules, in priority order:
  - halt already 1: register frozen; en and flush ignored until reset.
  - flush=1: bubble latched (valid=0, regWrite=0, halt=0, data fields 0). Applies regardless of en, so flush wins over en.
  - en=1: all *_in fields captured.
  - en=0: hold current contents.
- Writeback select (combinational from latched fields):
  - jal=1 gives npc.
  - else memtoReg=1 gives dmemload.
  - else aluOut.
  - jal has priority over memtoReg.
- Write enable: wen = valid & regWrite & (regSel != 0); writes to $zero are suppressed.
- wsel equals the latched regSel even when wen=0.
- Halt:
  - halt rises on the edge that captures valid_in=1 & halt_in=1 (not flushed).
  - Stays 1 until RST.
  - A halt instruction never writes the register file.
- fwd_valid mirrors wen; forwarding data is wdat and forwarding select is wsel.
- No arithmetic other than the counter; all data is 32-bit passthrough.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - retired increments by 1 on every edge where en=1, flush=0, halt=0 and valid_in=1 are all true.
  - A halt instruction counts.
  - Wraps modulo 2^CNT_W.
  - Frozen once halt=1.
- Undefined:
  - No counter register; retired tied to 0.
  - Everything else identical.

Decomposition:
- cpu_types_pkg carries word_t, regbits_t (5-bit) and a new enum wbsel_t (WB_ALU, WB_MEM, WB_NPC) used for the select encoding.
- Port bundle goes in a new interface stage_wb_if with a modport for this stage, mirroring the existing stage-interface style.
- Sub-module retire_counter (parameterised by CNT_W, inputs inc/freeze) instantiated only under WB_RETIRE_CNT_EN.

Test Plan:
- Reset: assert RST mid-cycle with valid contents latched -> all outputs 0 immediately, asynchronously; retired=0.
- ALU write: en=1, valid_in=1, regWrite_in=1, regSel_in=5, aluOut_in=0x0000_00FF -> next cycle wen=1, wsel=5, wdat=0xFF, fwd_valid=1.
- Select priority: memtoReg_in=1 with dmemload_in=0xDEADBEEF -> wdat=0xDEADBEEF. Then jal_in=1 and memtoReg_in=1 with npc_in=0x44, regSel_in=31 -> wdat=0x44, wsel=31.
- Zero register and hold: regSel_in=0, regWrite_in=1 -> wen=0. Then en=0 with changed inputs for 3 cycles -> outputs unchanged.
- Flush versus en: flush=1 and en=1 with regWrite_in=1 -> wen=0; with WB_RETIRE_CNT_EN, retired unchanged.
- Halt: capture halt_in=1, valid_in=1 -> halt=1, wen=0. Then 10 further advances with regWrite_in=1 -> halt stays 1, wen stays 0, retired frozen (e.g. stays 7 after 6 instructions plus the halt).
